muldiv_unit: RTL

- Multi-cycle multiply/divide unit beside the ALU in the execute stage. It owns the architectural HI/LO registers.
- It accepts MULT/MULTU/DIV/DIVU from id_ex and computes iteratively over 32 cycles.
- While busy, it raises a stall that the hazard logic ORs into its pipeline freeze.
- It serves MFHI/MFLO reads and MTHI/MTLO writes.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_datapath.sv | 35 +++
 rtl/muldiv_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 64;
  // Sliced down to DATA_WIDTH at the point of use.
  localparam logic [MAX_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

  function automatic logic op_is_div(input op_t o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_t o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// One iteration of unsigned shift-add multiply or restoring divide
// on the shared 2*DATA_WIDTH accumulator.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]              op,
  input  logic [DATA_WIDTH-1:0]   operand,
  input  logic [2*DATA_WIDTH-1:0] acc,
  output logic [2*DATA_WIDTH-1:0] acc_next
);

  localparam int W = DATA_WIDTH;

  logic [W:0]   add_sum;
  logic [W:0]   shifted;
  logic         ge;
  logic [W-1:0] rem_next;

  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}.
    add_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : '0);
    // Divide: acc = {partial remainder, remaining dividend / quotient bits}.
    shifted  = {acc[2*W-1:W], acc[W-1]};
    ge       = shifted >= {1'b0, operand};
    rem_next = ge ? (shifted[W-1:0] - operand) : shifted[W-1:0];
    if (op_is_div(op_t'(op))) begin
      acc_next = {rem_next, acc[W-2:0], ge};
    end else begin
      acc_next = {add_sum, acc[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO; 32 iterations plus one
// sign-fix cycle, with pipeline stall and flush handling.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] rsData,
  input  logic [DATA_WIDTH-1:0] rtData,
  input  logic                  writeHi,
  input  logic                  writeLo,
  input  logic                  readHiLo,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  busy,
  output logic                  done,
  output logic                  stall
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  state_t         state;
  logic [1:0]     op_reg;
  logic [CW-1:0]  count;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_next;
  logic [W-1:0]   operand;
  logic [W-1:0]   dividend_raw;
  logic           neg_main;
  logic           neg_rem;
  logic           div_zero;
  logic [W-1:0]   hi_reg;
  logic [W-1:0]   lo_reg;
  logic           busy_reg;
  logic           done_reg;

  // Operand capture at the accept edge.
  logic           in_signed;
  logic           in_div;
  logic           rs_neg;
  logic           rt_neg;
  logic [W-1:0]   rs_mag;
  logic [W-1:0]   rt_mag;

  // Sign-corrected results for the FIX cycle.
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix;
  logic [W-1:0]   rem_fix;

  always_comb begin
    in_signed = op_is_signed(op_t'(op));
    in_div    = op_is_div(op_t'(op));
    rs_neg    = in_signed & rsData[W-1];
    rt_neg    = in_signed & rtData[W-1];
    rs_mag    = rs_neg ? (~rsData + 1'b1) : rsData;
    rt_mag    = rt_neg ? (~rtData + 1'b1) : rtData;
  end

  always_comb begin
    prod_fix = neg_main ? (~acc + 1'b1) : acc;
    quot_fix = neg_main ? (~acc[W-1:0] + 1'b1) : acc[W-1:0];
    rem_fix  = neg_rem ? (~acc[2*W-1:W] + 1'b1) : acc[2*W-1:W];
  end

  muldiv_datapath #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_datapath (
    .op      (op_reg),
    .operand (operand),
    .acc     (acc),
    .acc_next(acc_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      op_reg       <= OP_MULT;
      count        <= '0;
      acc          <= '0;
      operand      <= '0;
      dividend_raw <= '0;
      neg_main     <= 1'b0;
      neg_rem      <= 1'b0;
      div_zero     <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (!flush) begin
            if (writeHi || writeLo) begin
              if (writeHi) hi_reg <= rsData;
              if (writeLo) lo_reg <= rsData;
            end else if (start) begin
              op_reg       <= op;
              count        <= CW'(DATA_WIDTH - 1);
              operand      <= in_div ? rt_mag : rs_mag;
              acc          <= {{W{1'b0}}, (in_div ? rs_mag : rt_mag)};
              dividend_raw <= rsData;
              neg_main     <= rs_neg ^ rt_neg;
              neg_rem      <= rs_neg;
              div_zero     <= in_div && (rtData == '0);
              busy_reg     <= 1'b1;
              state        <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            busy_reg <= 1'b0;
            state    <= IDLE;
          end else begin
            acc <= acc_next;
            if (count == '0) begin
              state <= FIX;
            end else begin
              count <= count - 1'b1;
            end
          end
        end
        FIX: begin
          busy_reg <= 1'b0;
          state    <= IDLE;
          if (!flush) begin
            done_reg <= 1'b1;
            if (div_zero) begin
              lo_reg <= DIV_ZERO_QUOTIENT[W-1:0];
              hi_reg <= dividend_raw;
            end else if (op_is_div(op_t'(op_reg))) begin
              lo_reg <= quot_fix;
              hi_reg <= rem_fix;
            end else begin
              lo_reg <= prod_fix[W-1:0];
              hi_reg <= prod_fix[2*W-1:W];
            end
          end
        end
        default: begin
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign hi    = hi_reg;
  assign lo    = lo_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;
  assign stall = busy_reg && (start || readHiLo || writeHi || writeLo);

endmodule
